// File: rtl/lc_switch_pkg.sv
// Shared constants, types and helpers for the Language Card / Saturn soft-switch sequencer.
package lc_switch_pkg;

  localparam logic [11:0] LC_PAGE         = 12'hC08;
  localparam logic [11:0] SAT_PAGE        = 12'hC09;
  localparam int unsigned SAT_BANKSEL_BIT = 2;
  localparam int unsigned MAX_ACC         = 5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_GNT,
    ST_SETUP,
    ST_TOGGLE,
    ST_HOLD,
    ST_FIN
  } state_t;

  typedef struct packed {
    logic [15:0] addr;
  } acc_entry_t;

  typedef struct packed {
    logic       lc_bank1;
    logic       lc_rd;
    logic       lc_wr;
    logic       sat_en;
    logic       sat_bank_b;
    logic       sat_rd;
    logic       sat_wr;
    logic [2:0] sat_bank16k;
  } targets_t;

  // Low nibble for a read/write-enable switch; wr needs a0=1 and a double access to arm.
  function automatic logic [3:0] state_nibble(input logic bank, input logic rd, input logic wr);
    return {bank, 1'b0, (wr ? rd : ~rd), wr};
  endfunction

endpackage

// File: rtl/lc_access_list.sv
// Combinational access list: maps latched targets and an index to a soft-switch address.
module lc_access_list
  import lc_switch_pkg::*;
(
  input  targets_t   tgt,
  input  logic [2:0] index,
  output acc_entry_t entry,
  output logic [2:0] count
);

  logic [2:0] lc_n;
  logic [2:0] sat_n;
  logic [3:0] banksel;

  always_comb begin
    lc_n    = tgt.lc_wr ? 3'd2 : 3'd1;
    sat_n   = tgt.sat_en ? (tgt.sat_wr ? 3'd3 : 3'd2) : 3'd0;
    count   = lc_n + sat_n;

    banksel                  = '0;
    banksel[SAT_BANKSEL_BIT] = 1'b1;
    banksel[3]               = tgt.sat_bank16k[2];
    banksel[1:0]             = tgt.sat_bank16k[1:0];

    // Order: LC state (1-2 entries), Saturn bank select, Saturn state (1-2 entries).
    if (index < lc_n)
      entry.addr = {LC_PAGE, state_nibble(tgt.lc_bank1, tgt.lc_rd, tgt.lc_wr)};
    else if (index == lc_n)
      entry.addr = {SAT_PAGE, banksel};
    else
      entry.addr = {SAT_PAGE, state_nibble(tgt.sat_bank_b, tgt.sat_rd, tgt.sat_wr)};
  end

endmodule

// File: rtl/lc_switch_sequencer.sv
// Bus initiator that replays soft-switch reads to restore LC/Saturn card state.
module lc_switch_sequencer
  import lc_switch_pkg::*;
#(
  parameter int unsigned HOLD_CYC = 2
) (
  input  logic        mclk28,
  input  logic        reset_in,
  input  logic        start,
  input  logic        tgt_lc_bank1,
  input  logic        tgt_lc_rd,
  input  logic        tgt_lc_wr,
  input  logic        tgt_sat_en,
  input  logic        tgt_sat_bankB,
  input  logic        tgt_sat_rd,
  input  logic        tgt_sat_wr,
  input  logic [2:0]  tgt_sat_bank16k,
  input  logic        bus_gnt,
  output logic        bus_req,
  output logic [15:0] addr,
  output logic        we,
  output logic        strobe,
  output logic        busy,
  output logic        done
);

  localparam int unsigned HCW = $clog2(HOLD_CYC) + 1;

  state_t         state;
  targets_t       tgt_q;
  logic [2:0]     idx;
  logic [HCW-1:0] hold_cnt;
  logic           gnt_lost;
  acc_entry_t     entry;
  logic [2:0]     count;

  lc_access_list u_list (
    .tgt   (tgt_q),
    .index (idx),
    .entry (entry),
    .count (count)
  );

  always_ff @(posedge mclk28) begin
    if (reset_in) begin
      state    <= ST_IDLE;
      tgt_q    <= '0;
      idx      <= '0;
      hold_cnt <= '0;
      gnt_lost <= 1'b0;
      bus_req  <= 1'b0;
      addr     <= '0;
      we       <= 1'b0;
      strobe   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      we   <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            tgt_q <= '{lc_bank1:    tgt_lc_bank1,
                       lc_rd:       tgt_lc_rd,
                       lc_wr:       tgt_lc_wr,
                       sat_en:      tgt_sat_en,
                       sat_bank_b:  tgt_sat_bankB,
                       sat_rd:      tgt_sat_rd,
                       sat_wr:      tgt_sat_wr,
                       sat_bank16k: tgt_sat_bank16k};
            idx     <= '0;
            busy    <= 1'b1;
            bus_req <= 1'b1;
            state   <= ST_WAIT_GNT;
          end
        end
        ST_WAIT_GNT: begin
          if (bus_gnt) state <= ST_SETUP;
        end
        ST_SETUP: begin
          if (!bus_gnt) begin
            state <= ST_WAIT_GNT;
          end else begin
            addr  <= entry.addr;
            state <= ST_TOGGLE;
          end
        end
        ST_TOGGLE: begin
          strobe   <= ~strobe;
          hold_cnt <= '0;
          gnt_lost <= ~bus_gnt;
          state    <= ST_HOLD;
        end
        ST_HOLD: begin
          // A lost grant only defers the next entry; the issued access always completes its hold.
          if (hold_cnt == HCW'(HOLD_CYC - 1)) begin
            gnt_lost <= 1'b0;
            if (idx == count - 3'd1) begin
              state <= ST_FIN;
            end else begin
              idx   <= idx + 3'd1;
              state <= (gnt_lost || !bus_gnt) ? ST_WAIT_GNT : ST_SETUP;
            end
          end else begin
            hold_cnt <= hold_cnt + HCW'(1);
            if (!bus_gnt) gnt_lost <= 1'b1;
          end
        end
        ST_FIN: begin
          done    <= 1'b1;
          bus_req <= 1'b0;
          busy    <= 1'b0;
          addr    <= '0;
          state   <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lc_switch_sequencer.sv
// Scoreboard bench: expected soft-switch accesses are queued at start and matched per strobe edge.
module tb_lc_switch_sequencer;

  localparam int unsigned HOLD = 2;

  logic        mclk28 = 1'b0;
  logic        reset_in;
  logic        start;
  logic        tgt_lc_bank1, tgt_lc_rd, tgt_lc_wr;
  logic        tgt_sat_en, tgt_sat_bankB, tgt_sat_rd, tgt_sat_wr;
  logic [2:0]  tgt_sat_bank16k;
  logic        bus_gnt;
  logic        bus_req, we, strobe, busy, done;
  logic [15:0] addr;

  lc_switch_sequencer #(.HOLD_CYC(HOLD)) dut (
    .mclk28          (mclk28),
    .reset_in        (reset_in),
    .start           (start),
    .tgt_lc_bank1    (tgt_lc_bank1),
    .tgt_lc_rd       (tgt_lc_rd),
    .tgt_lc_wr       (tgt_lc_wr),
    .tgt_sat_en      (tgt_sat_en),
    .tgt_sat_bankB   (tgt_sat_bankB),
    .tgt_sat_rd      (tgt_sat_rd),
    .tgt_sat_wr      (tgt_sat_wr),
    .tgt_sat_bank16k (tgt_sat_bank16k),
    .bus_gnt         (bus_gnt),
    .bus_req         (bus_req),
    .addr            (addr),
    .we              (we),
    .strobe          (strobe),
    .busy            (busy),
    .done            (done)
  );

  always #5 mclk28 = ~mclk28;

  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc   = 0;
  int          ndone = 0;
  int          ntog  = 0;
  logic [15:0] exp_addr[$];
  int          exp_done[$];
  int          gnt_mode = 0;   // 0: tied high, 1: random, 2: gnt_manual
  logic        gnt_manual = 1'b1;
  logic        rst_q = 1'b1;
  logic        prev_strobe = 1'b0;
  int          hold_left = 0;
  logic [15:0] cur_addr = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail(input string name, input string what);
    n_cmp++;
    n_err++;
    $display("FAIL %s: %s (cycle %0d)", name, what, cyc);
  endtask

  always @(posedge mclk28) begin
    cyc   <= cyc + 1;
    rst_q <= reset_in;
  end

  always @(posedge mclk28) begin
    #2;
    if (gnt_mode == 0)      bus_gnt = 1'b1;
    else if (gnt_mode == 1) bus_gnt = ($urandom_range(0, 3) != 0);
    else                    bus_gnt = gnt_manual;
  end

  // Monitor: every strobe transition is one access and must match the next expected address.
  always @(negedge mclk28) begin
    int e;
    if (rst_q) begin
      prev_strobe = strobe;
      hold_left   = 0;
    end else begin
      if (hold_left > 0) begin
        chk("addr_hold", addr, cur_addr);
        hold_left--;
      end
      if (strobe !== prev_strobe) begin
        ntog++;
        if (exp_addr.size() == 0) begin
          fail("extra_toggle", $sformatf("unexpected access at %h", addr));
        end else begin
          cur_addr = exp_addr.pop_front();
          chk("toggle_addr", addr, cur_addr);
          chk("we_low", we, 0);
          chk("toggle_req", bus_req, 1);
          hold_left = HOLD - 1;
        end
      end
      prev_strobe = strobe;
      if (done) begin
        ndone++;
        if (exp_done.size() == 0) begin
          fail("unexpected_done", "done pulse with no sequence outstanding");
        end else begin
          e = exp_done.pop_front();
          if (e >= 0) chk("done_latency", cyc, e);
          chk("done_all_issued", exp_addr.size(), 0);
          chk("done_busy", busy, 0);
          chk("done_req", bus_req, 0);
          chk("done_addr", addr, 16'h0000);
        end
      end
    end
  end

  // Apple II LC/Saturn switch table: rd/wr combination -> low two address bits.
  function automatic logic [15:0] sw_code(input logic rd, input logic wr);
    if (rd && wr) return 16'd3;
    if (wr)       return 16'd1;
    if (rd)       return 16'd0;
    return 16'd2;
  endfunction

  // t = {lc_bank1, lc_rd, lc_wr, sat_en, sat_bankB, sat_rd, sat_wr, sat_bank16k[2:0]}
  task automatic push_model(input logic [9:0] t, output int n);
    logic [15:0] a;
    n = 0;
    a = 16'hC080 + (t[9] ? 16'd8 : 16'd0) + sw_code(t[8], t[7]);
    for (int i = 0; i < (t[7] ? 2 : 1); i++) begin exp_addr.push_back(a); n++; end
    if (t[6]) begin
      a = 16'hC094 + (t[2] ? 16'd8 : 16'd0) + (t[1] ? 16'd2 : 16'd0) + (t[0] ? 16'd1 : 16'd0);
      exp_addr.push_back(a); n++;
      a = 16'hC090 + (t[5] ? 16'd8 : 16'd0) + sw_code(t[4], t[3]);
      for (int i = 0; i < (t[3] ? 2 : 1); i++) begin exp_addr.push_back(a); n++; end
    end
  endtask

  task automatic drive_tgt(input logic [9:0] t);
    {tgt_lc_bank1, tgt_lc_rd, tgt_lc_wr, tgt_sat_en, tgt_sat_bankB,
     tgt_sat_rd, tgt_sat_wr, tgt_sat_bank16k} = t;
  endtask

  task automatic issue(input logic [9:0] t, input bit timed);
    int n;
    @(posedge mclk28); #1;
    drive_tgt(t);
    push_model(t, n);
    exp_done.push_back(timed ? cyc + 3 + 4 * n : -1);
    start = 1'b1;
    @(posedge mclk28); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int limit);
    int d0;
    int k;
    d0 = ndone;
    k  = 0;
    while (ndone == d0 && k < limit) begin @(posedge mclk28); k++; end
    if (ndone == d0) fail("done_timeout", "sequence did not complete");
  endtask

  task automatic wait_tog(input int base, input int limit);
    int k;
    k = 0;
    while (ntog == base && k < limit) begin @(posedge mclk28); #1; k++; end
    if (ntog == base) fail("toggle_timeout", "no access issued");
  endtask

  initial begin
    int t0;
    reset_in = 1'b1;
    start    = 1'b0;
    drive_tgt('0);
    repeat (3) @(posedge mclk28);
    #1 reset_in = 1'b0;
    @(negedge mclk28);
    chk("rst_addr", addr, 16'h0000);
    chk("rst_strobe", strobe, 0);
    chk("rst_req", bus_req, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_we", we, 0);

    // Directed: LC bank2 rd+wr, LC bank1 wr-only, LC bank2 off, LC rd + Saturn bank 5.
    issue(10'b0_1_1_0_0_0_0_000, 1'b1); wait_done(200);
    issue(10'b1_0_1_0_0_0_0_000, 1'b1); wait_done(200);
    issue(10'b0_0_0_0_0_0_0_000, 1'b1); wait_done(200);
    issue(10'b0_1_0_1_1_1_0_101, 1'b1); wait_done(200);

    // Grant dropped during the hold of the first of a double access.
    gnt_mode = 2; gnt_manual = 1'b1;
    t0 = ntog;
    issue(10'b0_1_1_0_0_0_0_000, 1'b0);
    wait_tog(t0, 100);
    gnt_manual = 1'b0;
    repeat (20) @(posedge mclk28);
    #1;
    chk("drop_one_toggle", ntog - t0, 1);
    chk("drop_addr_held", addr, 16'hC083);
    chk("drop_busy", busy, 1);
    chk("drop_req", bus_req, 1);
    gnt_manual = 1'b1;
    wait_done(200);
    chk("drop_total_toggles", ntog - t0, 2);
    gnt_mode = 0;

    // start while busy must be ignored.
    issue(10'b1_1_1_1_0_1_1_010, 1'b1);
    repeat (6) @(posedge mclk28);
    #1 drive_tgt(10'b0_0_0_1_1_0_0_111); start = 1'b1;
    @(posedge mclk28); #1 start = 1'b0;
    wait_done(200);

    // Randomized targets, alternating tied and random grant.
    for (int i = 0; i < 40; i++) begin
      gnt_mode = i % 2;
      issue(10'($urandom), gnt_mode == 0);
      wait_done(600);
    end
    gnt_mode = 0;

    // Reset mid-hold aborts with no done pulse.
    t0 = ntog;
    issue(10'b0_0_1_1_1_1_1_011, 1'b1);
    wait_tog(t0, 100);
    reset_in = 1'b1;
    @(posedge mclk28); #1;
    exp_addr.delete();
    exp_done.delete();
    reset_in = 1'b0;
    @(negedge mclk28);
    chk("abort_addr", addr, 16'h0000);
    chk("abort_strobe", strobe, 0);
    chk("abort_req", bus_req, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    repeat (30) @(posedge mclk28);
    issue(10'b1_1_0_1_0_0_1_110, 1'b1); wait_done(200);

    repeat (5) @(posedge mclk28);
    chk("end_addr_queue", exp_addr.size(), 0);
    chk("end_done_queue", exp_done.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/lc_switch_sequencer.md
Name: lc_switch_sequencer

Overview:
- Bus initiator that programs the Language Card (slot 0, $C08x) and Saturn128 (slot 1, $C09x) soft-switch state by replaying the CPU soft-switch accesses those cards decode.
- Used by the OSD/save-state path to restore a target memory-card configuration after reset or load.
- Drives addr/we/strobe into the card decoder in place of the 6502 while it holds the bus via a req/gnt handshake.

Parameters:
- HOLD_CYC, 2, cycles addr stays stable after each strobe toggle (min 2: the decoder compares strobe against its 1-cycle delayed copy).

Ports:
- mclk28  in  1  system clock; all logic on rising edge
- reset_in  in  1  synchronous, active-high reset
- start  in  1  1-cycle pulse; latch targets and begin sequence
- tgt_lc_bank1  in  1  LC target: 1 = $D000 bank 1 (addr[3]=1)
- tgt_lc_rd  in  1  LC target read enable
- tgt_lc_wr  in  1  LC target write enable
- tgt_sat_en  in  1  1 = also program Saturn
- tgt_sat_bankB  in  1  Saturn $D000 bank select
- tgt_sat_rd  in  1  Saturn read enable
- tgt_sat_wr  in  1  Saturn write enable
- tgt_sat_bank16k  in  3  Saturn 16K bank
- bus_gnt  in  1  arbiter grant; may drop at any time
- bus_req  out  1  bus request
- addr  out  16  soft-switch address
- we  out  1  CPU write flag; always 0 (all accesses are reads)
- strobe  out  1  access strobe; every transition (either polarity) is one access
- busy  out  1  sequence in progress
- done  out  1  1-cycle pulse when sequence completes

Behaviour:
- Reset values: bus_req=0, addr=16'h0000, we=0, strobe=0, busy=0, done=0, FSM=IDLE, access index=0. Because addr returns to $0000 in the reset cycle, the strobe reset edge never decodes as a switch access.
- start is accepted only in IDLE. It latches all tgt_* and builds an ordered access list of up to 5 entries (index 0..4). start while busy is ignored.
- LC entries, in order:
  - nibble n = {bank1, 0, a1, a0}.
  - wr=1: a0=1, a1=rd; address $C080|n issued twice (double read arms write enable).
  - wr=0: a0=0, a1=~rd; address issued once.
- Saturn entries, only if tgt_sat_en, after the LC entries:
  - Bank select once: $C090|{b[2], 1, b[1], b[0]}.
  - State: $C090|{bankB, 0, a1, a0}, with the same a1/a0/double-issue rule as LC.
- List length: 1..5.
- FSM states:
  - IDLE: on start, set busy=1 and bus_req=1, go to WAIT_GNT.
  - WAIT_GNT: stay until bus_gnt=1, then go to SETUP.
  - SETUP (1 cycle): drive addr for the current entry, go to TOGGLE.
  - TOGGLE (1 cycle): strobe <= ~strobe, addr held, go to HOLD.
  - HOLD (HOLD_CYC cycles): addr held. On the last hold cycle, advance to SETUP of the next entry, or to FIN after the last entry.
  - FIN (1 cycle): done=1, bus_req=0, busy=0, addr=$0000, then IDLE.
- Each access takes 2+HOLD_CYC cycles. With HOLD_CYC=2 and an immediate grant, 5 accesses finish in 20 cycles after WAIT_GNT exits, plus the FIN cycle.
- bus_gnt drop:
  - In SETUP: hold strobe, go to WAIT_GNT, redo the current entry.
  - In TOGGLE/HOLD (toggle already issued): finish the hold with addr stable, then go to WAIT_GNT before the next entry. An access is never re-issued, so write-arm counts stay exact.
- strobe is never reset mid-sequence except by reset_in.
- reset_in mid-sequence aborts immediately to reset values; no done pulse. The card decoder must share the same reset.
- we stays 0 throughout, so the LC pre-write arm (qualified by ~we) works.

Decomposition:
- Package lc_switch_pkg:
  - constants LC_PAGE=12'hC08, SAT_PAGE=12'hC09, SAT_BANKSEL_BIT=2, MAX_ACC=5;
  - FSM state enum;
  - access-entry typedef {addr[15:0]}.
- Sub-module lc_access_list (combinational): from the latched targets, produce entry[index] and the entry count. The top module holds the FSM, index counter and hold counter.

Test Plan:
- LC bank2, rd=1, wr=1, sat_en=0, gnt tied 1 -> strobe toggles twice, addr $C083 each time, done 1 cycle after second hold.
- LC bank1, rd=0, wr=1 -> two toggles at $C089; LC rd=0, wr=0, bank2 -> one toggle at $C082.
- sat_en=1, bank16k=5, bankB=1, rd=1, wr=0, LC bank2 rd-only -> toggles at $C080, $C09D, $C098, in that order.
- bus_gnt deasserted during HOLD of the 1st of a double access -> addr held through hold, then idle (no toggles) until regrant. Exactly 2 toggles total at that address.
- start pulsed while busy -> ignored, access list unchanged; reset_in asserted mid-HOLD -> next cycle addr=$0000, strobe=0, bus_req=0, no done.
